// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stop-watch control block.
package stopwatch_pkg;

  localparam int unsigned COUNT_W = 24;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    RUN       = 3'd1,
    PAUSE     = 3'd2,
    LAP_RUN   = 3'd3,
    LAP_PAUSE = 3'd4,
    DONE      = 3'd5
  } sw_state_t;

  // States in which the timer chain is being advanced
  function automatic logic is_running(input sw_state_t s);
    return (s == RUN) || (s == LAP_RUN);
  endfunction

  // States in which the display shows the lap snapshot
  function automatic logic is_lap(input sw_state_t s);
    return (s == LAP_RUN) || (s == LAP_PAUSE);
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Prescaler that turns TICK_DIV advancing clk edges into one registered strobe.
// The count only moves on advancing edges, so a pause keeps the fractional period.
module tick_prescaler #(
  parameter int unsigned TICK_DIV = 1000000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic advance,
  input  logic clr,
  input  logic suppress,
  output logic tick,
  output logic at_wrap
);

  localparam int unsigned CntW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            tick_d;

  // High while the count sits on its last value; the next advance wraps it
  assign at_wrap = (cnt_q == CntW'(TICK_DIV - 1));

  // Next count and strobe; suppress keeps the wrap but withholds the strobe
  always_comb begin
    cnt_d  = cnt_q;
    tick_d = 1'b0;
    if (clr) begin
      cnt_d = '0;
    end else if (advance) begin
      if (at_wrap) begin
        cnt_d  = '0;
        tick_d = ~suppress;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Count and strobe registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
      tick  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tick  <= tick_d;
    end
  end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stop-watch control FSM: button pulses to tick strobe, chain clear and display value.
// Pulse priority on a shared edge: clear > start_stop > saturation > lap.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int unsigned TICK_DIV    = 1000000,
  parameter int unsigned MAX_COUNT   = 1000000,
  parameter int unsigned STOP_AT_MAX = 0
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start_stop,
  input  logic               lap,
  input  logic               clear,
  input  logic [COUNT_W-1:0] time_count,
  output logic               tick_enable,
  output logic               timer_clear,
  output logic [COUNT_W-1:0] display_value,
  output logic               running,
  output logic               lap_active,
  output logic [2:0]         state_dbg
);

  sw_state_t          state_q, state_d;
  logic [COUNT_W-1:0] lap_q, lap_d;
  logic               advance;
  logic               at_wrap;
  logic               sat_hit;

  // The prescaler only moves on plain running edges; clear/start_stop freeze it
  assign advance = is_running(state_q) && !clear && !start_stop;

  // Chain is on its last value and this edge would roll it over
  assign sat_hit = (STOP_AT_MAX != 0) && advance && at_wrap &&
                   (time_count == COUNT_W'(MAX_COUNT - 1));

  tick_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_prescaler (
    .clk      (clk),
    .reset_n  (reset_n),
    .advance  (advance),
    .clr      (clear),
    .suppress (sat_hit),
    .tick     (tick_enable),
    .at_wrap  (at_wrap)
  );

  // Next state and lap snapshot
  always_comb begin
    state_d = state_q;
    lap_d   = lap_q;
    if (clear) begin
      state_d = IDLE;
      lap_d   = '0;
    end else if (start_stop) begin
      unique case (state_q)
        IDLE:      state_d = RUN;
        RUN:       state_d = PAUSE;
        PAUSE:     state_d = RUN;
        LAP_RUN:   state_d = LAP_PAUSE;
        LAP_PAUSE: state_d = LAP_RUN;
        default:   state_d = state_q;
      endcase
    end else if (sat_hit) begin
      state_d = DONE;
    end else if (lap) begin
      unique case (state_q)
        RUN: begin
          state_d = LAP_RUN;
          lap_d   = time_count;
        end
        LAP_RUN:   state_d = RUN;
        LAP_PAUSE: state_d = PAUSE;
        default:   state_d = state_q;
      endcase
    end
  end

  // State, snapshot and all registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      lap_q         <= '0;
      display_value <= '0;
      timer_clear   <= 1'b0;
      running       <= 1'b0;
      lap_active    <= 1'b0;
    end else begin
      state_q       <= state_d;
      lap_q         <= lap_d;
      display_value <= is_lap(state_d) ? lap_d : time_count;
      timer_clear   <= clear;
      running       <= is_running(state_d);
      lap_active    <= is_lap(state_d);
    end
  end

  assign state_dbg = state_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl: a free-running and a saturating instance share the
// button pulses; each has its own modelled timer chain feeding time_count.
module tb_stopwatch_ctrl;

  localparam int TD = 4;
  localparam int MC = 10;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start_stop = 1'b0;
  logic        lap = 1'b0;
  logic        clear = 1'b0;
  logic [23:0] tc0 = '0, tc1 = '0;
  logic        tick0, tclr0, run0, lapa0, tick1, tclr1, run1, lapa1;
  logic [23:0] disp0, disp1;
  logic [2:0]  st0, st1;

  always #5 clk = ~clk;

  stopwatch_ctrl #(.TICK_DIV(TD), .MAX_COUNT(MC), .STOP_AT_MAX(0)) dut_free (
    .clk(clk), .reset_n(reset_n), .start_stop(start_stop), .lap(lap), .clear(clear),
    .time_count(tc0), .tick_enable(tick0), .timer_clear(tclr0), .display_value(disp0),
    .running(run0), .lap_active(lapa0), .state_dbg(st0)
  );

  stopwatch_ctrl #(.TICK_DIV(TD), .MAX_COUNT(MC), .STOP_AT_MAX(1)) dut_sat (
    .clk(clk), .reset_n(reset_n), .start_stop(start_stop), .lap(lap), .clear(clear),
    .time_count(tc1), .tick_enable(tick1), .timer_clear(tclr1), .display_value(disp1),
    .running(run1), .lap_active(lapa1), .state_dbg(st1)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int first_tick = -1;
  int tick_cnt = 0;

  // Behavioural model: mode flags, elapsed run edges, snapshot, chain value
  int m_started[2], m_go[2], m_lap[2], m_done[2];
  int m_phase[2], m_snap[2], m_tc[2], m_tick[2], m_clr[2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s (cycle %0d): got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_started[i] = 0; m_go[i] = 0; m_lap[i] = 0; m_done[i] = 0;
      m_phase[i] = 0; m_snap[i] = 0; m_tc[i] = 0; m_tick[i] = 0; m_clr[i] = 0;
    end
    tc0 = '0;
    tc1 = '0;
  endtask

  // One clock edge of the reference: returns the packed expected outputs
  task automatic model_step(input int i, input bit c, input bit s, input bit l,
                            output logic [31:0] expv);
    int tc, tcn, st, disp;
    bit adv, wrap, sat;
    tc   = m_tc[i];
    adv  = (m_go[i] != 0) && !c && !s;
    wrap = adv && (m_phase[i] == TD - 1);
    sat  = wrap && (i == 1) && (tc == MC - 1);
    if (c) m_phase[i] = 0;
    else if (adv) m_phase[i] = (m_phase[i] + 1) % TD;
    if (c) begin
      m_started[i] = 0; m_go[i] = 0; m_lap[i] = 0; m_done[i] = 0; m_snap[i] = 0;
    end else if (s) begin
      if (m_started[i] == 0) begin
        m_started[i] = 1; m_go[i] = 1;
      end else if (m_done[i] == 0) begin
        m_go[i] = (m_go[i] != 0) ? 0 : 1;
      end
    end else if (sat) begin
      m_done[i] = 1; m_go[i] = 0; m_lap[i] = 0;
    end else if (l && m_started[i] != 0 && m_done[i] == 0) begin
      if (m_lap[i] != 0) m_lap[i] = 0;
      else if (m_go[i] != 0) begin
        m_lap[i] = 1; m_snap[i] = tc;
      end
    end
    if (m_started[i] == 0) st = 0;
    else if (m_done[i] != 0) st = 5;
    else if (m_lap[i] == 0) st = (m_go[i] != 0) ? 1 : 2;
    else st = (m_go[i] != 0) ? 3 : 4;
    disp = (m_lap[i] != 0) ? m_snap[i] : tc;
    // External chain: acts on the strobes that were high during the cycle before this edge
    tcn = (m_clr[i] != 0) ? 0 : (m_tick[i] != 0) ? (tc + 1) % MC : tc;
    m_tick[i] = (wrap && !sat) ? 1 : 0;
    m_clr[i]  = c ? 1 : 0;
    m_tc[i]   = tcn;
    expv = {1'b0, m_tick[i][0], m_clr[i][0], m_go[i][0], m_lap[i][0], 3'(st), 24'(disp)};
  endtask

  task automatic do_cycle(input bit c, input bit s, input bit l);
    logic [31:0] e0, e1;
    clear = c; start_stop = s; lap = l;
    @(posedge clk);
    #1;
    cyc++;
    model_step(0, c, s, l, e0);
    model_step(1, c, s, l, e1);
    check("free", {1'b0, tick0, tclr0, run0, lapa0, st0, disp0}, e0);
    check("sat", {1'b0, tick1, tclr1, run1, lapa1, st1, disp1}, e1);
    if (tick0) begin
      tick_cnt++;
      if (first_tick < 0) first_tick = cyc;
    end
    clear = 1'b0; start_stop = 1'b0; lap = 1'b0;
    tc0 = 24'(m_tc[0]);
    tc1 = 24'(m_tc[1]);
  endtask

  task automatic force_tc(input int v);
    m_tc[0] = v; m_tc[1] = v;
    tc0 = 24'(v); tc1 = 24'(v);
  endtask

  initial begin
    model_reset();
    #2;
    check("reset_free", {1'b0, tick0, tclr0, run0, lapa0, st0, disp0}, 32'h0);
    check("reset_sat", {1'b0, tick1, tclr1, run1, lapa1, st1, disp1}, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;

    // Start at edge 2; strobes expected after edges 6, 10, 14
    do_cycle(0, 0, 0);
    do_cycle(0, 1, 0);
    while (cyc < 14) do_cycle(0, 0, 0);
    check("first_tick_edge", 32'(first_tick), 32'd6);
    check("ticks_by_edge14", 32'(tick_cnt), 32'd3);

    // Pause with prescaler at 2, hold 20 cycles, resume
    do_cycle(0, 0, 0);
    do_cycle(0, 0, 0);
    do_cycle(0, 1, 0);
    tick_cnt = 0;
    for (int k = 0; k < 20; k++) do_cycle(0, 0, 0);
    check("no_tick_in_pause", 32'(tick_cnt), 32'd0);
    do_cycle(0, 1, 0);
    for (int k = 0; k < 6; k++) do_cycle(0, 0, 0);

    // Lap freeze at 5, chain advances, release
    do_cycle(1, 0, 0);
    do_cycle(0, 0, 0);
    do_cycle(0, 1, 0);
    force_tc(5);
    do_cycle(0, 0, 1);
    for (int k = 0; k < 14; k++) do_cycle(0, 0, 0);
    check("lap_hold", 32'(disp0), 32'd5);
    do_cycle(0, 0, 1);
    for (int k = 0; k < 3; k++) do_cycle(0, 0, 0);

    // All three pulses together while in LAP_RUN
    do_cycle(0, 0, 1);
    do_cycle(0, 0, 0);
    do_cycle(1, 1, 1);
    do_cycle(0, 0, 0);
    do_cycle(0, 0, 0);
    check("clear_all_state", 32'(st0), 32'd0);

    // Saturation: chain held at MAX_COUNT-1 across the wrap edge
    do_cycle(0, 1, 0);
    for (int k = 0; k < TD; k++) begin
      force_tc(MC - 1);
      do_cycle(0, 0, 0);
    end
    check("sat_done", 32'(st1), 32'd5);
    do_cycle(0, 1, 0);
    do_cycle(0, 0, 1);
    check("done_sticky", 32'(st1), 32'd5);
    do_cycle(1, 0, 0);
    check("done_cleared", 32'(st1), 32'd0);

    // Randomized traffic
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(29) == 0) force_tc(int'($urandom_range(MC - 1)));
      do_cycle($urandom_range(59) == 0, $urandom_range(11) == 0, $urandom_range(9) == 0);
    end

    // Asynchronous reset mid-run in LAP_RUN, checked before any clk edge
    do_cycle(1, 0, 0);
    do_cycle(0, 1, 0);
    do_cycle(0, 0, 1);
    for (int k = 0; k < TD + 1; k++) do_cycle(0, 0, 0);
    check("pre_reset_lap", 32'(st0), 32'd3);
    #3;
    reset_n = 1'b0;
    #1;
    check("async_free", {1'b0, tick0, tclr0, run0, lapa0, st0, disp0}, 32'h0);
    check("async_sat", {1'b0, tick1, tclr1, run1, lapa1, st1, disp1}, 32'h0);
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    for (int k = 0; k < 200; k++) begin
      if ($urandom_range(29) == 0) force_tc(int'($urandom_range(MC - 1)));
      do_cycle($urandom_range(59) == 0, $urandom_range(11) == 0, $urandom_range(9) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
